// File: rtl/dram_pattern_tester_if.sv
// Bus-request bundle between the DRAM pattern tester (master) and the DRAM
// wrapper (slave). Signal names are as seen from the tester side.
interface dram_pattern_tester_if #(
    parameter int WORD_SIZE = 256
) ();
    logic                 cyc_o;
    logic                 stb_o;
    logic                 we_o;
    logic [31:0]          addr_o;
    logic [WORD_SIZE-1:0] data_o;
    logic [WORD_SIZE-1:0] data_i;
    logic                 ack_i;

    modport master (
        output cyc_o, stb_o, we_o, addr_o, data_o,
        input  data_i, ack_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, addr_o, data_o,
        output data_i, ack_i
    );
endinterface

// File: rtl/dram_pattern_tester.sv
// DRAM pattern tester: after calibration it writes an address-derived pattern
// to NUM_WORDS words, reads them back and compares, reporting pass/fail.
// Optional build macro TESTER_LOOP_EN: clean passes repeat automatically and
// err_count_o shows the number of clean passes instead of the mismatch count.
module dram_pattern_tester #(
    parameter int          WORD_SIZE      = 256,
    parameter int          ADDR_WIDTH     = 25,
    parameter int          NUM_WORDS      = 1024,
    parameter int          START_DELAY    = 1000,
    parameter int          TIMEOUT_CYCLES = 65535,
    parameter logic [31:0] SEED           = 32'hA5A5_0000
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  initialized_i,
    input  logic                  start_i,
    dram_pattern_tester_if.master bus,
    output logic                  busy_o,
    output logic                  pass_o,
    output logic                  fail_o,
    output logic                  timeout_o,
    output logic [15:0]           err_count_o,
    output logic [ADDR_WIDTH-1:0] first_err_addr_o
);
    localparam int LANES = WORD_SIZE / 32;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [15:0]           TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0]           DELAY_LD = 16'(START_DELAY);

    typedef enum logic [2:0] {
        S_IDLE, S_DELAY, S_WRITE, S_WAIT_WRITE, S_READ, S_WAIT_READ, S_CHECK, S_DONE
    } state_t;

    // Lane k of word idx carries SEED ^ (idx*LANES + k), wrapping at 32 bits.
    function automatic logic [WORD_SIZE-1:0] pattern(input logic [ADDR_WIDTH-1:0] idx);
        logic [WORD_SIZE-1:0] w;
        logic [31:0]          base;
        base = 32'(idx) * 32'(LANES);
        w    = '0;
        for (int k = 0; k < LANES; k++) begin
            w[32*k +: 32] = SEED ^ (base + 32'(k));
        end
        return w;
    endfunction

    state_t                state_q, state_d;
    logic [15:0]           delay_q, delay_d;
    logic [15:0]           tmo_q, tmo_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                  cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [31:0]           addr_q, addr_d;
    logic [WORD_SIZE-1:0]  data_q, data_d;
    logic [WORD_SIZE-1:0]  rdata_q;
    logic                  busy_q, busy_d, pass_q, pass_d, fail_q, fail_d;
    logic                  timeout_q, timeout_d;
    logic [15:0]           err_q, err_d;
    logic [ADDR_WIDTH-1:0] ferr_q, ferr_d;
    logic [15:0]           loop_q, loop_d;

    // Next-state and next-output logic for the test sequencer.
    always_comb begin
        state_d   = state_q;
        delay_d   = delay_q;
        tmo_d     = tmo_q;
        idx_d     = idx_q;
        cyc_d     = cyc_q;
        stb_d     = stb_q;
        we_d      = we_q;
        addr_d    = addr_q;
        data_d    = data_q;
        busy_d    = busy_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        timeout_d = timeout_q;
        err_d     = err_q;
        ferr_d    = ferr_q;
        loop_d    = loop_q;

        case (state_q)
            S_IDLE: begin
                if (initialized_i) begin
                    delay_d = DELAY_LD;
                    state_d = S_DELAY;
                end
            end
            S_DELAY: begin
                if (delay_q <= 16'd1) begin
                    state_d   = S_WRITE;
                    idx_d     = '0;
                    err_d     = '0;
                    ferr_d    = '0;
                    loop_d    = '0;
                    busy_d    = 1'b1;
                    pass_d    = 1'b0;
                    fail_d    = 1'b0;
                    timeout_d = 1'b0;
                end else begin
                    delay_d = delay_q - 16'd1;
                end
            end
            S_WRITE, S_READ: begin
                // Bus stays idle this cycle; the request is registered on exit.
                cyc_d  = 1'b1;
                stb_d  = 1'b1;
                we_d   = (state_q == S_WRITE);
                addr_d = 32'(idx_q) << 7;
                if (state_q == S_WRITE) begin
                    data_d = pattern(idx_q);
                end
                tmo_d   = '0;
                state_d = (state_q == S_WRITE) ? S_WAIT_WRITE : S_WAIT_READ;
            end
            S_WAIT_WRITE, S_WAIT_READ: begin
                if (bus.ack_i) begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                    we_d  = 1'b0;
                    if (state_q == S_WAIT_READ) begin
                        state_d = S_CHECK;
                    end else if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = S_READ;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_WRITE;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    cyc_d     = 1'b0;
                    stb_d     = 1'b0;
                    we_d      = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            S_CHECK: begin
                if (rdata_q != pattern(idx_q)) begin
                    if (err_q != 16'hFFFF) begin
                        err_d = err_q + 16'd1;
                    end
                    if (err_q == 16'd0) begin
                        ferr_d = idx_q;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_READ;
                end
            end
            S_DONE: begin
`ifdef TESTER_LOOP_EN
                if (!fail_q) begin
                    // Clean pass: go straight into another write sweep.
                    state_d = S_WRITE;
                    idx_d   = '0;
                    err_d   = '0;
                    ferr_d  = '0;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                end else if (start_i) begin
                    delay_d = DELAY_LD;
                    state_d = S_DELAY;
                end
`else
                if (start_i) begin
                    delay_d = DELAY_LD;
                    state_d = S_DELAY;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase

        // Verdict is computed once, on the transition into DONE.
        if (state_d == S_DONE && state_q != S_DONE) begin
            busy_d = 1'b0;
            pass_d = (err_d == 16'd0) && !timeout_d;
            fail_d = !((err_d == 16'd0) && !timeout_d);
            if ((err_d == 16'd0) && !timeout_d) begin
                loop_d = loop_q + 16'd1;
            end
        end

        // Losing calibration aborts everything and waits for it to return.
        if (!initialized_i && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            cyc_d     = 1'b0;
            stb_d     = 1'b0;
            we_d      = 1'b0;
            busy_d    = 1'b0;
            pass_d    = 1'b0;
            fail_d    = 1'b0;
            timeout_d = 1'b0;
            err_d     = '0;
            ferr_d    = '0;
            loop_d    = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            delay_q   <= '0;
            tmo_q     <= '0;
            idx_q     <= '0;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= '0;
            ferr_q    <= '0;
            loop_q    <= '0;
        end else begin
            state_q   <= state_d;
            delay_q   <= delay_d;
            tmo_q     <= tmo_d;
            idx_q     <= idx_d;
            cyc_q     <= cyc_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
            ferr_q    <= ferr_d;
            loop_q    <= loop_d;
        end
    end

    // Read data is captured on the acknowledging cycle for the CHECK compare.
    always_ff @(posedge sys_clk) begin
        if (state_q == S_WAIT_READ && bus.ack_i) begin
            rdata_q <= bus.data_i;
        end
    end

    assign bus.cyc_o        = cyc_q;
    assign bus.stb_o        = stb_q;
    assign bus.we_o         = we_q;
    assign bus.addr_o       = addr_q;
    assign bus.data_o       = data_q;
    assign busy_o           = busy_q;
    assign pass_o           = pass_q;
    assign fail_o           = fail_q;
    assign timeout_o        = timeout_q;
    assign first_err_addr_o = ferr_q;
`ifdef TESTER_LOOP_EN
    assign err_count_o      = loop_q;
`else
    assign err_count_o      = err_q;
`endif
endmodule

// File: tb/tb_dram_pattern_tester.sv
// Directed bench for dram_pattern_tester: 4 words, 2-cycle start delay,
// 8-cycle bus timeout and a small memory model acking one cycle after it
// sees a strobe (two cycles of strobe per transaction).
module tb_dram_pattern_tester;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        init;
    logic        start;
    logic        busy, pass, fail, tmo;
    logic [15:0] errc;
    logic [24:0] ferr;

    int vectors     = 0;
    int miscompares = 0;

    dram_pattern_tester_if #(.WORD_SIZE(256)) bus ();

    dram_pattern_tester #(
        .WORD_SIZE(256), .ADDR_WIDTH(25), .NUM_WORDS(4), .START_DELAY(2),
        .TIMEOUT_CYCLES(8), .SEED(32'hA5A5_0000)
    ) dut (
        .sys_clk(clk), .rst_n(rst_n), .initialized_i(init), .start_i(start),
        .bus(bus), .busy_o(busy), .pass_o(pass), .fail_o(fail),
        .timeout_o(tmo), .err_count_o(errc), .first_err_addr_o(ferr)
    );

    always #5 clk = ~clk;

    // Memory model: 4 words, optional bit-0 corruption on read, optional
    // refusal to ack a write to one word index.
    logic [255:0] mem [4];
    logic [3:0]   flip_mask = 4'b0000;
    int           noack_idx = -1;
    int           wr_cnt = 0;
    int           rd_cnt = 0;
    logic [31:0]  wr_addr_log [$];
    logic [255:0] wr_data_log [$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ack_i <= 1'b0;
        end else begin
            bus.ack_i <= 1'b0;
            if (bus.cyc_o && bus.stb_o && !bus.ack_i) begin
                if (bus.we_o) begin
                    if (int'(bus.addr_o[8:7]) != noack_idx) begin
                        bus.ack_i <= 1'b1;
                        mem[bus.addr_o[8:7]] <= bus.data_o;
                        wr_addr_log.push_back(bus.addr_o);
                        wr_data_log.push_back(bus.data_o);
                        wr_cnt++;
                    end
                end else begin
                    bus.ack_i  <= 1'b1;
                    bus.data_i <= mem[bus.addr_o[8:7]] ^ {255'd0, flip_mask[bus.addr_o[8:7]]};
                    rd_cnt++;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts negedges from now until a verdict appears.
    task automatic run_until_verdict(output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n++;
            if (pass || fail) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_busy(input logic lvl, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (busy === lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_req(input logic we, input logic [31:0] addr, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.stb_o && bus.we_o == we && bus.addr_o == addr) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_start;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin : stim
        bit ok;
        int n;
        int wr0, rd0;

        rst_n = 1'b0;
        init  = 1'b0;
        start = 1'b0;
        #12;
        check("rst_cyc", 32'(bus.cyc_o), 0);
        check("rst_stb", 32'(bus.stb_o), 0);
        check("rst_addr", bus.addr_o, 0);
        check("rst_data_nz", 32'(|bus.data_o), 0);
        check("rst_status", {26'd0, busy, pass, fail, tmo, |errc, |ferr}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_no_init_busy", 32'(busy), 0);
        check("idle_no_init_cyc", 32'(bus.cyc_o), 0);

`ifdef TESTER_LOOP_EN
        // Looping: clean passes count up on err_count_o, first failure stops.
        init = 1'b1;
        for (int p = 1; p <= 3; p++) begin
            ok = 1'b0;
            for (int i = 0; i < 400; i++) begin
                @(negedge clk);
                if (pass) begin
                    ok = 1'b1;
                    break;
                end
            end
            check("loop_pass_seen", 32'(ok), 1);
            check("loop_count", 32'(errc), 32'(p));
        end
        flip_mask = 4'b1000;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (fail) begin
                ok = 1'b1;
                break;
            end
        end
        check("loop_fail_seen", 32'(ok), 1);
        check("loop_fail_count", 32'(errc), 3);
        check("loop_fail_pass", 32'(pass), 0);
        repeat (20) @(negedge clk);
        check("loop_stopped_fail", 32'(fail), 1);
        check("loop_stopped_busy", 32'(busy), 0);
        check("loop_stopped_cyc", 32'(bus.cyc_o), 0);
`else
        // 1. Clean pass, timed from the initialized rise.
        wr0 = wr_addr_log.size();
        rd0 = rd_cnt;
        init = 1'b1;
        run_until_verdict(n, ok);
        check("clean_done", 32'(ok), 1);
        check("clean_cycles", n, 31);
        check("clean_wr_count", wr_addr_log.size() - wr0, 4);
        check("clean_rd_count", rd_cnt - rd0, 4);
        if (wr_addr_log.size() >= wr0 + 4) begin
            check("wr_addr0", wr_addr_log[wr0 + 0], 32'h000);
            check("wr_addr1", wr_addr_log[wr0 + 1], 32'h080);
            check("wr_addr2", wr_addr_log[wr0 + 2], 32'h100);
            check("wr_addr3", wr_addr_log[wr0 + 3], 32'h180);
            check("wr1_lane0", wr_data_log[wr0 + 1][31:0], 32'hA5A5_0008);
            check("wr3_lane7", wr_data_log[wr0 + 3][255:224], 32'hA5A5_001F);
        end
        check("clean_pass", 32'(pass), 1);
        check("clean_fail", 32'(fail), 0);
        check("clean_errc", 32'(errc), 0);
        check("clean_busy", 32'(busy), 0);
        check("clean_tmo", 32'(tmo), 0);

        // 2. Bit flips on words 2 and 3.
        flip_mask = 4'b1100;
        pulse_start();
        wait_busy(1'b1, ok);
        check("flip_busy_rise", 32'(ok), 1);
        wait_busy(1'b0, ok);
        check("flip_busy_fall", 32'(ok), 1);
        check("flip_fail", 32'(fail), 1);
        check("flip_pass", 32'(pass), 0);
        check("flip_errc", 32'(errc), 2);
        check("flip_ferr", 32'(ferr), 2);

        // 3. Third write never acked.
        flip_mask = 4'b0000;
        noack_idx = 2;
        pulse_start();
        wait_req(1'b1, 32'h100, ok);
        check("tmo_req_seen", 32'(ok), 1);
        n = 0;
        while (bus.cyc_o && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("tmo_cyc_cycles", n, 8);
        check("tmo_flag", 32'(tmo), 1);
        check("tmo_fail", 32'(fail), 1);
        check("tmo_pass", 32'(pass), 0);
        check("tmo_busy", 32'(busy), 0);
        noack_idx = -1;

        // 4. Calibration lost during the second read, then regained.
        flip_mask = 4'b0001;
        pulse_start();
        wait_req(1'b0, 32'h080, ok);
        check("loss_req_seen", 32'(ok), 1);
        check("loss_err_before", 32'(errc), 1);
        init = 1'b0;
        @(negedge clk);
        check("loss_cyc", 32'(bus.cyc_o), 0);
        check("loss_stb", 32'(bus.stb_o), 0);
        check("loss_status", {27'd0, busy, pass, fail, tmo, |errc}, 0);
        repeat (4) @(negedge clk);
        check("loss_idle_cyc", 32'(bus.cyc_o), 0);
        flip_mask = 4'b0000;
        init = 1'b1;
        run_until_verdict(n, ok);
        check("regain_done", 32'(ok), 1);
        check("regain_cycles", n, 31);
        check("regain_pass", 32'(pass), 1);

        // 5. Asynchronous reset mid-write, then a start re-run.
        pulse_start();
        wait_req(1'b1, 32'h000, ok);
        check("rst_req_seen", 32'(ok), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_cyc", 32'(bus.cyc_o), 0);
        check("arst_we", 32'(bus.we_o), 0);
        check("arst_data_nz", 32'(|bus.data_o), 0);
        check("arst_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_until_verdict(n, ok);
        check("post_rst_cycles", n, 31);
        check("post_rst_pass", 32'(pass), 1);
        pulse_start();
        wait_busy(1'b1, ok);
        check("rerun_busy", 32'(ok), 1);
        check("rerun_pass_cleared", 32'(pass), 0);
        wait_busy(1'b0, ok);
        check("rerun_done", 32'(ok), 1);
        check("rerun_pass", 32'(pass), 1);
        check("rerun_fail", 32'(fail), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dram_pattern_tester.md
# dram_pattern_tester

Self-checking traffic generator that drives the bus-request side of the DRAM wrapper on the board top level. After the controller reports `initialized`, it writes an address-derived pattern to a window of DRAM words, reads every word back, and compares it. Results drive the pass/fail LEDs and a small status bundle for debug.

## Interface

Parameters:
- `WORD_SIZE`, 256: data width in bits; must be a multiple of 32. `LANES = WORD_SIZE/32`.
- `ADDR_WIDTH`, 25: word-index width; `addr_o = {index, 7'h0}`.
- `NUM_WORDS`, 1024: words tested, covering indices 0..NUM_WORDS-1. Range 1..2^ADDR_WIDTH.
- `START_DELAY`, 1000: cycles to wait after `initialized_i` rises before the first request. Range 0..65535.
- `TIMEOUT_CYCLES`, 65535: maximum wait for `ack_i` per transaction.
- `SEED`, 32'hA5A5_0000: pattern seed.

Ports (reset is asynchronous and active-low):
- `sys_clk` in 1: single clock for the block.
- `rst_n` in 1: asynchronous, active-low reset.
- `initialized_i` in 1: DRAM calibration done.
- `start_i` in 1: a one-cycle pulse in DONE re-runs the test.
- `cyc_o`, `stb_o`, `we_o` out 1 each: bus request.
- `addr_o` out 32: byte address.
- `data_o` out WORD_SIZE: write data.
- `data_i` in WORD_SIZE: read data.
- `ack_i` in 1: transaction complete.
- `busy_o` out 1: test running.
- `pass_o`, `fail_o` out 1 each: final verdict.
- `timeout_o` out 1: a bus transaction timed out.
- `err_count_o` out 16: mismatching words, saturating.
- `first_err_addr_o` out ADDR_WIDTH: index of the first mismatching word.

## Operation

Expected pattern for word `i`: lane `k` (bits `32k+31:32k`) = `SEED ^ (i*LANES + k)`, computed mod 2^32.

States:
- **IDLE**: waits for `initialized_i`, then loads the delay counter.
- **DELAY**: counts `START_DELAY` cycles, then clears index, errors and verdicts, sets `busy_o`, and goes to WRITE.
- **WRITE**: bus is idle for this cycle. On exit, registers `cyc/stb/we=1`, `addr_o`, and `data_o=pattern(index)`.
- **WAIT_WRITE**: holds all bus outputs until `ack_i`. On ack, drops `cyc/stb/we`. If `index==NUM_WORDS-1`, resets index to 0 and goes to READ; otherwise increments index and goes to WRITE.
- **READ**: same as WRITE but with `we=0`; `data_o` keeps its last value.
- **WAIT_READ**: on `ack_i`, captures `data_i` into a register and drops `cyc/stb`, then goes to CHECK.
- **CHECK**: compares the captured word with `pattern(index)`. On mismatch:
  - `err_count_o` increments and saturates at 16'hFFFF.
  - The first mismatch latches `first_err_addr_o`.
  - Next state is READ with index+1, or DONE after the last word.
- **DONE**: `busy_o=0`; `pass_o = (err_count==0 && !timeout)`; `fail_o = !pass_o`. A `start_i` pulse goes to DELAY.

Boundary rules:
- **Timeout**: a counter clears on entry to WAIT_WRITE or WAIT_READ. If it reaches `TIMEOUT_CYCLES` without an ack, the block drops `cyc/stb/we`, sets `timeout_o`, and goes to DONE, giving `fail_o=1`.
- **Stray ack**: `ack_i` outside the WAIT states is ignored.
- **Loss of `initialized_i`**: if it falls in any state other than IDLE, the bus drops the next cycle, the state returns to IDLE, and all status outputs clear. The test restarts when it rises again.
- **`start_i` outside DONE** is ignored.
- **`NUM_WORDS=1`**: one write, one read.

## Timing

- **Reset values**: every output is 0, state is IDLE.
- **Per write**: 1 idle cycle (WRITE) plus N cycles, where `ack_i` arrives N≥1 cycles after `stb_o` rises. Bus outputs fall on the cycle after ack is sampled.
- **Per read**: 1 (READ) + N + 1 (CHECK).
- **Zero-wait ack** (N=1): a full pass takes `START_DELAY + 1 + NUM_WORDS*2 + NUM_WORDS*3` cycles from the `initialized_i` rise to DONE.
- **Verdict**: valid from the first DONE cycle and held until the next run starts or reset.

## Configuration

`TESTER_LOOP_EN`:
- **Defined**: DONE with `fail_o=0` automatically returns to WRITE after 1 cycle. A 16-bit `loop_count` increments per clean pass (wrapping) and is exposed on `err_count_o`. The first failure stops the block in DONE.
- **Undefined**: single run; `err_count_o` reports mismatches as specified.

## Test plan

Bench uses `NUM_WORDS=4`, `START_DELAY=2`, and a memory model with 2-cycle ack.

1. **Clean pass**:
   - Memory returns the written data.
   - Expect 4 writes at addr 0x00, 0x80, 0x100, 0x180.
   - Expect word 1, lane 0 = 32'hA5A5_0008.
   - Then 4 reads, then `pass_o=1`, `fail_o=0`, `err_count_o=0`, `busy_o=0`.
2. **Bit flip**:
   - Model inverts bit 0 of words 2 and 3 on read.
   - Expect `fail_o=1`, `err_count_o=2`, `first_err_addr_o=2`.
3. **Timeout** (`TIMEOUT_CYCLES=8`):
   - Model never acks the 3rd write.
   - Expect `cyc_o` to drop 8 cycles after that write's `stb_o` rises, then `timeout_o=1`, `fail_o=1`, state DONE.
4. **Calibration loss**:
   - Drop `initialized_i` during the 2nd read.
   - Expect the bus to drop the next cycle and all status to be 0.
   - Raise it again; expect a full clean pass to complete.
5. **Reset and re-run**:
   - Assert `rst_n=0` mid-write; expect outputs 0 immediately (asynchronously).
   - After a clean pass, pulse `start_i`; expect a new run with `pass_o` cleared during `busy_o`.
6. **`TESTER_LOOP_EN`**:
   - Run with a clean memory; expect `err_count_o` to step 1, 2, 3 across passes.
   - Inject an error; expect a stop with `fail_o=1`.
